// File: rtl/lu_pkg.sv
// Shared types and default dimensions for the LU engine, this result buffer
// and the triangular inverse that consumes its rows.
package lu_pkg;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;

    typedef struct packed {
        logic [WIDTH-1:0] imag;
        logic [WIDTH-1:0] real_part;
    } cplx_t;

    typedef cplx_t [SIZE-1:0] row_t;

endpackage

// File: rtl/lu_result_buffer_if.sv
// Result-beat and row-read bus of the LU result buffer. The slave modport is
// the buffer itself; the master modport is the producer/consumer side.
interface lu_result_buffer_if #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64
);
    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE * 2 * WIDTH;

    logic [RW-1:0] l_col_i;
    logic [RW-1:0] u_row_i;
    logic [AW-1:0] result_addr_i;
    logic          result_valid_i;
    logic          result_ready_o;
    logic          rd_sel_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_valid_i;
    logic [RW-1:0] rd_row_o;
    logic [AW-1:0] rd_addr_o;
    logic          rd_sel_o;
    logic          rd_valid_o;
    logic          matrix_valid_o;
    logic          release_i;
    logic          busy_o;

    modport slave (
        input  l_col_i, u_row_i, result_addr_i, result_valid_i,
        output result_ready_o,
        input  rd_sel_i, rd_addr_i, rd_valid_i,
        output rd_row_o, rd_addr_o, rd_sel_o, rd_valid_o, matrix_valid_o,
        input  release_i,
        output busy_o
    );

    modport master (
        output l_col_i, u_row_i, result_addr_i, result_valid_i,
        input  result_ready_o,
        output rd_sel_i, rd_addr_i, rd_valid_i,
        input  rd_row_o, rd_addr_o, rd_sel_o, rd_valid_o, matrix_valid_o,
        output release_i,
        input  busy_o
    );
endinterface

// File: rtl/lu_result_buffer_bank.sv
// One bank of the ping-pong buffer: L columns and U rows as received, the
// per-index written mask, the full flag, and a combinational row mux that
// transposes the stored L columns into rows.
module lu_result_bank
    import lu_pkg::*;
#(
    parameter int SIZE  = lu_pkg::SIZE,
    parameter int WIDTH = lu_pkg::WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [$clog2(SIZE)-1:0]     wr_addr,
    input  logic [SIZE*2*WIDTH-1:0]     l_col,
    input  logic [SIZE*2*WIDTH-1:0]     u_row,
    input  logic                        clear_full,
    input  logic                        rd_sel,
    input  logic [$clog2(SIZE)-1:0]     rd_addr,
    output logic [SIZE*2*WIDTH-1:0]     rd_row,
    output logic                        full,
    output logic                        filling,
    output logic                        complete
);
    localparam int EW = 2 * WIDTH;
    localparam int RW = SIZE * EW;

    logic [RW-1:0]   lc_r [SIZE];
    logic [RW-1:0]   u_r  [SIZE];
    logic [SIZE-1:0] mask_r;
    logic [SIZE-1:0] mask_next_s;
    logic            full_r;

    // Mask as it would be after this write, and whether that write finishes the pair.
    always_comb begin
        mask_next_s = mask_r;
        if (wr_en) begin
            mask_next_s[wr_addr] = 1'b1;
        end else begin
            mask_next_s = mask_r;
        end
    end

    assign complete = wr_en & (&mask_next_s);
    assign full     = full_r;
    assign filling  = |mask_r;

    // Payload storage; deliberately unreset, validity is tracked by mask/full.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            lc_r[wr_addr] <= l_col;
            u_r[wr_addr]  <= u_row;
        end
    end

    // Fill tracking: the completing beat sets full and clears the mask together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            mask_r <= '0;
        end else if (flush) begin
            full_r <= 1'b0;
            mask_r <= '0;
        end else if (wr_en) begin
            if (complete) begin
                full_r <= 1'b1;
                mask_r <= '0;
            end else begin
                mask_r <= mask_next_s;
            end
        end else if (clear_full) begin
            full_r <= 1'b0;
        end
    end

    // Row mux: U rows verbatim, L rows gathered as element rd_addr of every column.
    always_comb begin
        rd_row = '0;
        for (int c = 0; c < SIZE; c++) begin
            if (rd_sel) begin
                rd_row[c*EW +: EW] = u_r[rd_addr][c*EW +: EW];
            end else begin
                rd_row[c*EW +: EW] = lc_r[c][rd_addr*EW +: EW];
            end
        end
    end

endmodule

// File: rtl/lu_result_buffer.sv
// Ping-pong L/U result buffer between the LU engine and the triangular
// inverse. Holds the write/read bank pointers, the result handshake, the
// registered one-cycle row-read stage, and flush handling.
module lu_result_buffer
    import lu_pkg::*;
#(
    parameter int SIZE  = lu_pkg::SIZE,
    parameter int WIDTH = lu_pkg::WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    lu_result_buffer_if.slave  bus
);
    localparam int AW = $clog2(SIZE);
    localparam int RW = SIZE * 2 * WIDTH;

    logic          wp_r;
    logic          rp_r;
    logic [1:0]    full_s;
    logic [1:0]    filling_s;
    logic [1:0]    complete_s;
    logic [1:0]    wr_en_s;
    logic [1:0]    clear_s;
    logic [RW-1:0] bank_row_s [2];
    logic          ready_s;
    logic          matrix_valid_s;
    logic          accept_s;
    logic          rd_fire_s;
    logic          rel_fire_s;

    logic          rd_valid_r;
    logic [AW-1:0] rd_addr_r;
    logic          rd_sel_r;
    logic [RW-1:0] rd_row_r;

    // Handshake decode; flush suppresses every state-changing event.
    always_comb begin
        ready_s        = ~full_s[wp_r];
        matrix_valid_s = full_s[rp_r];
        accept_s       = bus.result_valid_i & ready_s & ~flush_i;
        rd_fire_s      = bus.rd_valid_i & matrix_valid_s & ~flush_i;
        rel_fire_s     = bus.release_i & matrix_valid_s & ~flush_i;
        wr_en_s[0]     = accept_s & ~wp_r;
        wr_en_s[1]     = accept_s & wp_r;
        clear_s[0]     = rel_fire_s & ~rp_r;
        clear_s[1]     = rel_fire_s & rp_r;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        lu_result_bank #(.SIZE(SIZE), .WIDTH(WIDTH)) u_bank (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .flush      (flush_i),
            .wr_en      (wr_en_s[b]),
            .wr_addr    (bus.result_addr_i),
            .l_col      (bus.l_col_i),
            .u_row      (bus.u_row_i),
            .clear_full (clear_s[b]),
            .rd_sel     (bus.rd_sel_i),
            .rd_addr    (bus.rd_addr_i),
            .rd_row     (bank_row_s[b]),
            .full       (full_s[b]),
            .filling    (filling_s[b]),
            .complete   (complete_s[b])
        );
    end

    // Bank pointers: wp advances on completion, rp on an honoured release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_r <= 1'b0;
            rp_r <= 1'b0;
        end else if (flush_i) begin
            wp_r <= 1'b0;
            rp_r <= 1'b0;
        end else begin
            if (complete_s[wp_r]) begin
                wp_r <= ~wp_r;
            end
            if (rel_fire_s) begin
                rp_r <= ~rp_r;
            end
        end
    end

    // Registered read stage: row, address and select returned one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_r <= 1'b0;
            rd_addr_r  <= '0;
            rd_sel_r   <= 1'b0;
            rd_row_r   <= '0;
        end else if (flush_i) begin
            rd_valid_r <= 1'b0;
            rd_addr_r  <= '0;
            rd_sel_r   <= 1'b0;
            rd_row_r   <= '0;
        end else begin
            rd_valid_r <= rd_fire_s;
            if (rd_fire_s) begin
                rd_row_r  <= bank_row_s[rp_r];
                rd_addr_r <= bus.rd_addr_i;
                rd_sel_r  <= bus.rd_sel_i;
            end
        end
    end

    assign bus.result_ready_o = ready_s;
    assign bus.matrix_valid_o = matrix_valid_s;
    assign bus.busy_o         = full_s[0] | full_s[1] | filling_s[wp_r];
    assign bus.rd_valid_o     = rd_valid_r;
    assign bus.rd_addr_o      = rd_addr_r;
    assign bus.rd_sel_o       = rd_sel_r;
    assign bus.rd_row_o       = rd_row_r;

endmodule

// File: tb/tb_lu_result_buffer.sv
// Directed testbench for lu_result_buffer (SIZE=4, WIDTH=64).
module tb_lu_result_buffer;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int EW    = 2 * WIDTH;
    localparam int RW    = SIZE * EW;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

    lu_result_buffer_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    lu_result_buffer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Complex element {imag, real} as IEEE doubles.
    function automatic logic [EW-1:0] cx(int re, int im);
        return {$realtobits(real'(im)), $realtobits(real'(re))};
    endfunction

    // L column k of matrix m: element r = (10r+k+100m) + j(-(k+100m)).
    function automatic logic [RW-1:0] lcol(int m, int k);
        logic [RW-1:0] v;
        for (int r = 0; r < SIZE; r++) v[r*EW +: EW] = cx(10*r + k + 100*m, -(k + 100*m));
        return v;
    endfunction

    // U row k of matrix m: every element = (k+100m) + j(1+m).
    function automatic logic [RW-1:0] urow(int m, int k);
        logic [RW-1:0] v;
        for (int c = 0; c < SIZE; c++) v[c*EW +: EW] = cx(k + 100*m, 1 + m);
        return v;
    endfunction

    // Expected L row r of matrix m: element c = element r of column c.
    function automatic logic [RW-1:0] lrow(int m, int r);
        logic [RW-1:0] v;
        for (int c = 0; c < SIZE; c++) v[c*EW +: EW] = cx(10*r + c + 100*m, -(c + 100*m));
        return v;
    endfunction

    task automatic chk(string tag, logic [RW-1:0] obs, logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int m, int k);
        bus.l_col_i        = lcol(m, k);
        bus.u_row_i        = urow(m, k);
        bus.result_addr_i  = 2'(k);
        bus.result_valid_i = 1'b1;
        step();
        bus.result_valid_i = 1'b0;
    endtask

    task automatic do_read(string tag, logic sel, int addr, logic [RW-1:0] exp);
        bus.rd_sel_i   = sel;
        bus.rd_addr_i  = 2'(addr);
        bus.rd_valid_i = 1'b1;
        step();
        bus.rd_valid_i = 1'b0;
        chk({tag, "_valid"}, RW'(bus.rd_valid_o), RW'(1));
        chk({tag, "_addr"},  RW'(bus.rd_addr_o),  RW'(addr));
        chk({tag, "_sel"},   RW'(bus.rd_sel_o),   RW'(sel));
        chk({tag, "_row"},   bus.rd_row_o,        exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.l_col_i = '0;
        bus.u_row_i = '0;
        bus.result_addr_i = 2'd0;
        bus.result_valid_i = 1'b0;
        bus.rd_sel_i = 1'b0;
        bus.rd_addr_i = 2'd0;
        bus.rd_valid_i = 1'b0;
        bus.release_i = 1'b0;
        step();
        step();
        chk("rst_ready", RW'(bus.result_ready_o), RW'(1));
        chk("rst_mv",    RW'(bus.matrix_valid_o), RW'(0));
        chk("rst_busy",  RW'(bus.busy_o),         RW'(0));
        chk("rst_rdv",   RW'(bus.rd_valid_o),     RW'(0));
        rst_n = 1'b1;
        step();

        // Matrix 0 in order into bank 0.
        send(0, 0); send(0, 1); send(0, 2);
        chk("a_mv_partial", RW'(bus.matrix_valid_o), RW'(0));
        chk("a_busy",       RW'(bus.busy_o),         RW'(1));
        send(0, 3);
        chk("a_mv",    RW'(bus.matrix_valid_o), RW'(1));
        chk("a_ready", RW'(bus.result_ready_o), RW'(1));
        do_read("a_l2", 1'b0, 2, lrow(0, 2));
        do_read("a_u3", 1'b1, 3, urow(0, 3));
        step();
        chk("a_rdv_idle", RW'(bus.rd_valid_o), RW'(0));
        bus.release_i = 1'b1;
        step();
        bus.release_i = 1'b0;
        chk("a_rel_mv",   RW'(bus.matrix_valid_o), RW'(0));
        chk("a_rel_busy", RW'(bus.busy_o),         RW'(0));

        // Matrix 1 into bank 1: out of order with a duplicate index.
        send(1, 3); send(9, 1); send(1, 1); send(1, 0);
        chk("b_mv_partial", RW'(bus.matrix_valid_o), RW'(0));
        chk("b_busy",       RW'(bus.busy_o),         RW'(1));
        send(1, 2);
        chk("b_mv", RW'(bus.matrix_valid_o), RW'(1));
        do_read("b_l1", 1'b0, 1, lrow(1, 1));
        do_read("b_u1", 1'b1, 1, urow(1, 1));

        // Matrix 2 into bank 0 with no release: both banks full.
        send(2, 0); send(2, 1); send(2, 2); send(2, 3);
        chk("c_ready_full", RW'(bus.result_ready_o), RW'(0));
        bus.l_col_i = lcol(3, 0);
        bus.u_row_i = urow(3, 0);
        bus.result_addr_i = 2'd0;
        bus.result_valid_i = 1'b1;
        step();
        chk("c_stall", RW'(bus.result_ready_o), RW'(0));
        bus.release_i = 1'b1;
        step();
        bus.release_i = 1'b0;
        chk("c_ready_rel", RW'(bus.result_ready_o), RW'(1));
        chk("c_mv_rel",    RW'(bus.matrix_valid_o), RW'(1));
        step();
        bus.result_valid_i = 1'b0;
        do_read("c_l0", 1'b0, 0, lrow(2, 0));

        // Last beat of bank 1 coincides with release of bank 0 and a read.
        send(3, 1); send(3, 2);
        bus.l_col_i = lcol(3, 3);
        bus.u_row_i = urow(3, 3);
        bus.result_addr_i = 2'd3;
        bus.result_valid_i = 1'b1;
        bus.release_i = 1'b1;
        bus.rd_sel_i = 1'b0;
        bus.rd_addr_i = 2'd3;
        bus.rd_valid_i = 1'b1;
        chk("d_mv_before", RW'(bus.matrix_valid_o), RW'(1));
        step();
        bus.result_valid_i = 1'b0;
        bus.release_i = 1'b0;
        bus.rd_valid_i = 1'b0;
        chk("d_mv_after", RW'(bus.matrix_valid_o), RW'(1));
        chk("d_rdv",      RW'(bus.rd_valid_o),     RW'(1));
        chk("d_row_old",  bus.rd_row_o,            lrow(2, 3));
        do_read("d_u0", 1'b1, 0, urow(3, 0));

        // Release bank 1, then read/release with nothing valid.
        bus.release_i = 1'b1;
        step();
        bus.release_i = 1'b0;
        chk("e_mv", RW'(bus.matrix_valid_o), RW'(0));
        bus.rd_valid_i = 1'b1;
        bus.release_i = 1'b1;
        step();
        bus.rd_valid_i = 1'b0;
        bus.release_i = 1'b0;
        chk("e_rdv_ignored", RW'(bus.rd_valid_o),     RW'(0));
        chk("e_mv_ignored",  RW'(bus.matrix_valid_o), RW'(0));
        send(4, 0); send(4, 1); send(4, 2); send(4, 3);
        chk("e_mv_rp_kept", RW'(bus.matrix_valid_o), RW'(1));
        do_read("e_u2", 1'b1, 2, urow(4, 2));

        // Flush mid-fill, with a read in flight.
        send(5, 0); send(5, 1);
        flush = 1'b1;
        bus.rd_sel_i = 1'b1;
        bus.rd_addr_i = 2'd2;
        bus.rd_valid_i = 1'b1;
        step();
        flush = 1'b0;
        bus.rd_valid_i = 1'b0;
        chk("f_rdv",   RW'(bus.rd_valid_o),     RW'(0));
        chk("f_row",   bus.rd_row_o,            RW'(0));
        chk("f_busy",  RW'(bus.busy_o),         RW'(0));
        chk("f_ready", RW'(bus.result_ready_o), RW'(1));
        chk("f_mv",    RW'(bus.matrix_valid_o), RW'(0));
        send(6, 0); send(6, 1); send(6, 2);
        chk("f_mv_partial", RW'(bus.matrix_valid_o), RW'(0));
        send(6, 3);
        chk("f_mv_full", RW'(bus.matrix_valid_o), RW'(1));
        do_read("f_l1", 1'b0, 1, lrow(6, 1));

        // Asynchronous reset mid-fill with a read pending.
        send(7, 0); send(7, 1);
        bus.rd_valid_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_busy",  RW'(bus.busy_o),         RW'(0));
        chk("r_ready", RW'(bus.result_ready_o), RW'(1));
        chk("r_mv",    RW'(bus.matrix_valid_o), RW'(0));
        step();
        chk("r_rdv", RW'(bus.rd_valid_o), RW'(0));
        bus.rd_valid_i = 1'b0;
        rst_n = 1'b1;
        send(8, 0); send(8, 1); send(8, 2);
        chk("r_mv_partial", RW'(bus.matrix_valid_o), RW'(0));
        send(8, 3);
        chk("r_mv_full", RW'(bus.matrix_valid_o), RW'(1));
        do_read("r_u3", 1'b1, 3, urow(8, 3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
